// File: rtl/ece429_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ece429_fetch_queue
// Brief    : Circular instruction queue between fetch and decode. Buffers
//            {pc, instr} pairs, presents the oldest to decode, stalls fetch
//            when full and empties in one cycle on a redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module ece429_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     enq_valid_in,
    input  logic [0:31]              enq_pc_in,
    input  logic [0:31]              enq_instr_in,
    input  logic                     deq_ready_in,
    input  logic                     flush_in,
    output logic                     stall_out,
    output logic                     deq_valid_out,
    output logic [0:31]              deq_pc_out,
    output logic [0:31]              deq_instr_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Entry storage; contents are never cleared, validity is tracked by count
    logic [0:31]   pc_mem    [DEPTH];
    logic [0:31]   instr_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          full;
    logic          not_empty;
    logic          do_enq;
    logic          do_deq;

    // Status and handshake qualification; flush overrides both transfers
    always_comb begin
        full      = (count == FULL_COUNT);
        not_empty = (count != '0);
        do_enq    = enq_valid_in && !full && !flush_in;
        do_deq    = deq_ready_in && not_empty && !flush_in;
    end

    // Pointer and occupancy state, cleared by reset or flush
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_enq && !do_deq) begin
                count <= count + 1'b1;
            end else if (!do_enq && do_deq) begin
                count <= count - 1'b1;
            end
        end
    end

    // Capture the fetched pair at the write pointer on an accepted enqueue
    always_ff @(posedge clk_in) begin
        if (do_enq) begin
            pc_mem[wr_ptr]    <= enq_pc_in;
            instr_mem[wr_ptr] <= enq_instr_in;
        end
    end

    // Outputs derive only from registered state; head data reads zero when empty
    always_comb begin
        stall_out     = full;
        deq_valid_out = not_empty;
        count_out     = count;
        deq_pc_out    = not_empty ? pc_mem[rd_ptr]    : 32'h0000_0000;
        deq_instr_out = not_empty ? instr_mem[rd_ptr] : 32'h0000_0000;
    end

endmodule
`default_nettype wire

// File: tb/tb_ece429_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ece429_fetch_queue
// Brief    : Scoreboard bench for ece429_fetch_queue. Stimulus pushes the
//            accepted entries into a queue; a negedge monitor compares the
//            DUT head and status against it. Directed checks cover fill,
//            drain, wrap streaming, flush precedence and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ece429_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n_in;
    logic          enq_valid_in;
    logic [0:31]   enq_pc_in;
    logic [0:31]   enq_instr_in;
    logic          deq_ready_in;
    logic          flush_in;
    logic          stall_out;
    logic          deq_valid_out;
    logic [0:31]   deq_pc_out;
    logic [0:31]   deq_instr_out;
    logic [CW-1:0] count_out;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t sb[$];

    ece429_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n_in),
        .enq_valid_in  (enq_valid_in),
        .enq_pc_in     (enq_pc_in),
        .enq_instr_in  (enq_instr_in),
        .deq_ready_in  (deq_ready_in),
        .flush_in      (flush_in),
        .stall_out     (stall_out),
        .deq_valid_out (deq_valid_out),
        .deq_pc_out    (deq_pc_out),
        .deq_instr_out (deq_instr_out),
        .count_out     (count_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: mid-cycle, compare DUT head/status with the scoreboard
    always @(negedge clk) begin
        if (mon_en && rst_n_in === 1'b1) begin
            chk("mon_count", 32'(count_out), 32'(sb.size()));
            chk("mon_stall", 32'(stall_out), 32'(sb.size() == DEPTH));
            chk("mon_valid", 32'(deq_valid_out), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                chk("mon_pc", deq_pc_out, sb[0].pc);
                chk("mon_instr", deq_instr_out, sb[0].instr);
            end else begin
                chk("mon_pc_empty", deq_pc_out, 32'h0);
                chk("mon_instr_empty", deq_instr_out, 32'h0);
            end
        end
    end

    // One cycle of stimulus; scoreboard updated at the edge with the accepted transfers
    task automatic step(input logic ev, input logic [31:0] pc, input logic dr, input logic fl);
        bit acc_enq;
        bit acc_deq;
        enq_valid_in = ev;
        enq_pc_in    = pc;
        enq_instr_in = instr_of(pc);
        deq_ready_in = dr;
        flush_in     = fl;
        @(posedge clk);
        acc_enq = ev && (sb.size() != DEPTH) && !fl;
        acc_deq = dr && (sb.size() != 0) && !fl;
        if (fl) begin
            sb.delete();
        end else begin
            if (acc_deq) void'(sb.pop_front());
            if (acc_enq) sb.push_back('{pc: pc, instr: instr_of(pc)});
        end
        #1;
    endtask

    initial begin
        rst_n_in     = 1'b0;
        enq_valid_in = 1'b0;
        enq_pc_in    = '0;
        enq_instr_in = '0;
        deq_ready_in = 1'b0;
        flush_in     = 1'b0;
        #2;
        chk("reset_count", 32'(count_out), 32'd0);
        chk("reset_valid", 32'(deq_valid_out), 32'd0);
        chk("reset_stall", 32'(stall_out), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n_in = 1'b1;
        mon_en   = 1'b1;

        // Fill and stall
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'h8002_0000 + 32'(4 * i), 1'b0, 1'b0);
            chk("fill_count", 32'(count_out), 32'(i + 1));
        end
        chk("fill_stall", 32'(stall_out), 32'd1);
        step(1'b1, 32'h8002_0010, 1'b0, 1'b0);
        chk("fill_blocked_count", 32'(count_out), 32'd4);
        chk("fill_head", deq_pc_out, 32'h8002_0000);

        // Drain in order
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_pc", deq_pc_out, 32'h8002_0000 + 32'(4 * i));
            chk("drain_instr", deq_instr_out, instr_of(32'h8002_0000 + 32'(4 * i)));
            step(1'b0, 32'h0, 1'b1, 1'b0);
        end
        chk("drain_valid", 32'(deq_valid_out), 32'd0);
        chk("drain_pc_zero", deq_pc_out, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("empty_deq_count", 32'(count_out), 32'd0);

        // Streaming with pointer wrap
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 32'h8002_0300 + 32'(4 * i), 1'b1, 1'b0);
            chk("stream_count", 32'(count_out), 32'd1);
            chk("stream_stall", 32'(stall_out), 32'd0);
            chk("stream_pc", deq_pc_out, 32'h8002_0300 + 32'(4 * i));
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stream_drained", 32'(count_out), 32'd0);

        // Flush precedence over enqueue and dequeue
        for (int i = 0; i < 3; i++) step(1'b1, 32'h8002_0400 + 32'(4 * i), 1'b0, 1'b0);
        chk("preflush_count", 32'(count_out), 32'd3);
        step(1'b1, 32'h8002_040C, 1'b1, 1'b1);
        chk("flush_count", 32'(count_out), 32'd0);
        chk("flush_valid", 32'(deq_valid_out), 32'd0);
        chk("flush_stall", 32'(stall_out), 32'd0);
        step(1'b1, 32'h8002_0100, 1'b0, 1'b0);
        chk("postflush_count", 32'(count_out), 32'd1);
        chk("postflush_pc", deq_pc_out, 32'h8002_0100);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Full plus simultaneous dequeue: only the dequeue happens
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h8002_0200 + 32'(4 * i), 1'b0, 1'b0);
        chk("full2_stall", 32'(stall_out), 32'd1);
        step(1'b1, 32'h8002_0210, 1'b1, 1'b0);
        chk("fulldeq_count", 32'(count_out), 32'd3);
        chk("fulldeq_stall", 32'(stall_out), 32'd0);
        chk("fulldeq_head", deq_pc_out, 32'h8002_0204);
        step(1'b1, 32'h8002_0210, 1'b0, 1'b0);
        chk("held_enq_count", 32'(count_out), 32'd4);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("fulldeq_drained", 32'(count_out), 32'd0);

        // Asynchronous reset mid-cycle with two entries loaded
        step(1'b1, 32'h8002_0500, 1'b0, 1'b0);
        step(1'b1, 32'h8002_0504, 1'b0, 1'b0);
        enq_valid_in = 1'b0;
        #1;
        rst_n_in = 1'b0;
        #1;
        chk("arst_count", 32'(count_out), 32'd0);
        chk("arst_valid", 32'(deq_valid_out), 32'd0);
        chk("arst_pc", deq_pc_out, 32'h0);
        chk("arst_instr", deq_instr_out, 32'h0);
        chk("arst_stall", 32'(stall_out), 32'd0);
        sb.delete();
        @(negedge clk);
        #1;
        rst_n_in = 1'b1;
        #1;
        chk("arst_release_count", 32'(count_out), 32'd0);
        step(1'b1, 32'h8002_0600, 1'b0, 1'b0);
        chk("post_reset_enq", deq_pc_out, 32'h8002_0600);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
